// File: rtl/four_bitcounter_pkg.sv
// Purpose: shared width, terminal-count constant and count type for four_bitcounter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents:
//   CNT_WIDTH - default count width in bits
//   CNT_MAX   - all-ones count at the default width (2^CNT_WIDTH - 1)
//   count_t   - CNT_WIDTH-bit count value
package four_bitcounter_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_MAX   = (1 << CNT_WIDTH) - 1;

  typedef logic [CNT_WIDTH-1:0] count_t;

endpackage : four_bitcounter_pkg

// File: rtl/four_bitcounter_incr.sv
// Purpose: combinational WIDTH-bit +1 incrementer with all-ones detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports:
//   val_i      [WIDTH-1:0]  current count value
//   next_o     [WIDTH-1:0]  val_i + 1, carry out dropped so all-ones wraps to zero
//   all_ones_o              high while val_i is 2^WIDTH - 1
module counter_incr
  import four_bitcounter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] next_o,
  output logic             all_ones_o
);

  // Sum is kept at WIDTH bits on purpose: the discarded carry is the wrap.
  assign next_o     = val_i + WIDTH'(1);
  assign all_ones_o = &val_i;

endmodule : counter_incr

// File: rtl/four_bitcounter.sv
// Purpose: free-running WIDTH-bit binary up-counter with terminal-count flag.
// Latency: q advances one step per rising clk edge; tc is a same-cycle decode of q.
// Backpressure: none; counts every edge while rst is low, no stall, enable or load.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset, clears q (and wrap_pulse) at once
//   q           [WIDTH-1:0] current count, straight from the state register
//   tc          high while q == 2^WIDTH - 1
//   wrap_pulse  (only with COUNTER_WRAP_PULSE_EN defined) one-cycle registered
//               pulse during the cycle after q steps from all-ones to zero
module four_bitcounter
  import four_bitcounter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef COUNTER_WRAP_PULSE_EN
  ,
  output logic             wrap_pulse
`endif
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;

  counter_incr #(
    .WIDTH (WIDTH)
  ) u_incr (
    .val_i      (cnt_q),
    .next_o     (cnt_d),
    .all_ones_o (at_max)
  );

  // Reset wins over any coincident clock edge, so release on an edge
  // leaves q at zero and counting begins on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q  = cnt_q;
  assign tc = at_max;

`ifdef COUNTER_WRAP_PULSE_EN
  logic wrap_q;
  logic wrap_d;

  // Sampling at_max on the same edge that takes q from all-ones to zero
  // makes the pulse coincide with the first zero cycle. A reset-driven
  // return to zero clears this register too, so it never pulses.
  assign wrap_d = at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;
`endif

endmodule : four_bitcounter

// File: tb/tb_four_bitcounter.sv
module tb_four_bitcounter;

  logic       clk;
  logic       rst;
  logic       rst3;
  logic [3:0] q;
  logic       tc;
  logic [2:0] q3;
  logic       tc3;
`ifdef COUNTER_WRAP_PULSE_EN
  logic       wrap_pulse;
  logic       wrap_pulse3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  four_bitcounter dut (
    .clk (clk),
    .rst (rst),
    .q   (q),
    .tc  (tc)
`ifdef COUNTER_WRAP_PULSE_EN
    ,
    .wrap_pulse (wrap_pulse)
`endif
  );

  four_bitcounter #(.WIDTH(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .q   (q3),
    .tc  (tc3)
`ifdef COUNTER_WRAP_PULSE_EN
    ,
    .wrap_pulse (wrap_pulse3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  vec_t vecs [0:21];

  typedef struct packed {
    logic [2:0] q;
    logic       tc;
  } vec3_t;

  vec3_t vecs3 [0:8];

  initial begin
    logic [3:0] rose;
    logic [3:0] fell;
    logic [3:0] prev;
`ifdef COUNTER_WRAP_PULSE_EN
    int pulses;
`endif

    // Reset held for two edges, then 20 counting edges: 1..15, 0, 1..4.
    vecs = '{
      '{1'b1, 4'd0,  1'b0}, '{1'b1, 4'd0,  1'b0},
      '{1'b0, 4'd1,  1'b0}, '{1'b0, 4'd2,  1'b0}, '{1'b0, 4'd3,  1'b0},
      '{1'b0, 4'd4,  1'b0}, '{1'b0, 4'd5,  1'b0}, '{1'b0, 4'd6,  1'b0},
      '{1'b0, 4'd7,  1'b0}, '{1'b0, 4'd8,  1'b0}, '{1'b0, 4'd9,  1'b0},
      '{1'b0, 4'd10, 1'b0}, '{1'b0, 4'd11, 1'b0}, '{1'b0, 4'd12, 1'b0},
      '{1'b0, 4'd13, 1'b0}, '{1'b0, 4'd14, 1'b0}, '{1'b0, 4'd15, 1'b1},
      '{1'b0, 4'd0,  1'b0}, '{1'b0, 4'd1,  1'b0}, '{1'b0, 4'd2,  1'b0},
      '{1'b0, 4'd3,  1'b0}, '{1'b0, 4'd4,  1'b0}
    };
    vecs3 = '{
      '{3'd1, 1'b0}, '{3'd2, 1'b0}, '{3'd3, 1'b0}, '{3'd4, 1'b0},
      '{3'd5, 1'b0}, '{3'd6, 1'b0}, '{3'd7, 1'b1}, '{3'd0, 1'b0},
      '{3'd1, 1'b0}
    };

    rst  = 1'b0;
    rst3 = 1'b0;
    #2;
    rst  = 1'b1;
    rst3 = 1'b1;
    #1;
    // Asynchronous clear before any clock edge has happened.
    chk("async_reset_q", 32'(q), 32'd0);
    chk("async_reset_tc", 32'(tc), 32'd0);
`ifdef COUNTER_WRAP_PULSE_EN
    chk("async_reset_wrap", 32'(wrap_pulse), 32'd0);
`endif

    // Table-driven: rst changes 1ns after an edge, well away from the next one.
    rose = '0;
    fell = '0;
    prev = 4'd0;
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst;
      tick();
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
      rose = rose | (q & ~prev);
      fell = fell | (~q & prev);
      prev = q;
    end
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("toggle_rise_bit%0d", b), 32'(rose[b]), 32'd1);
      chk($sformatf("toggle_fall_bit%0d", b), 32'(fell[b]), 32'd1);
    end

    // Mid-count asynchronous reset at 7.
    tick(); tick(); tick();
    chk("midcount_q7", 32'(q), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("midcount_async_q", 32'(q), 32'd0);
    chk("midcount_async_tc", 32'(tc), 32'd0);
    // Reset held across several edges: no increment.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_rst_q%0d", i), 32'(q), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_release_q5", 32'(q), 32'd5);

`ifdef COUNTER_WRAP_PULSE_EN
    // 32 edges from a fresh reset: pulse only on the zero cycles after each wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("wrap_q_k%0d", k), 32'(q), 32'(k % 16));
      chk($sformatf("wrap_pulse_k%0d", k), 32'(wrap_pulse), 32'((k % 16) == 0));
      if (wrap_pulse === 1'b1) pulses++;
    end
    chk("wrap_pulse_count", 32'(pulses), 32'd2);
    // Reset taken at 15 must not pulse.
    for (int k = 0; k < 15; k++) tick();
    chk("rst_at15_q", 32'(q), 32'd15);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_at15_async_wrap", 32'(wrap_pulse), 32'd0);
    tick();
    chk("rst_at15_hold_wrap", 32'(wrap_pulse), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_at15_rel_q", 32'(q), 32'd1);
    chk("rst_at15_rel_wrap", 32'(wrap_pulse), 32'd0);
`endif

    // Narrow instance has been held in reset all along.
    chk("w3_held_q", 32'(q3), 32'd0);
    chk("w3_held_tc", 32'(tc3), 32'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("w3_vec%0d_q", i), 32'(q3), 32'(vecs3[i].q));
      chk($sformatf("w3_vec%0d_tc", i), 32'(tc3), 32'(vecs3[i].tc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute backstop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule : tb_four_bitcounter
